// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the EX stage: funct codes, ALUOp encodings,
// mult/div FSM states and the mult/div iteration count.
package cpu_defs;

    localparam int unsigned MD_CYCLES = 32;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // mult, multu, div, divu occupy 0x18..0x1B
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers.
// op = funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
// Works on operand magnitudes; sign correction happens in the FIX state.
module muldiv_unit
    import cpu_defs::*;
#(
    parameter int unsigned MD_CYCLES = cpu_defs::MD_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        finishing,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, neg_q, neg_r, dbz;
    logic [31:0]       mag, acc_hi, acc_lo;
    logic [31:0]       step_hi, step_lo;
    logic              sa, sb;
    logic [31:0]       ma, mb;
    logic [32:0]       sum, part;
    logic [63:0]       prod;

    assign sa = ~op[0] & a[31];
    assign sb = ~op[0] & b[31];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    assign busy      = (state != MD_IDLE);
    assign finishing = (state == MD_FIX);

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= MD_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == CNT_W'(MD_CYCLES - 1)) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One shift-add (mult) or restoring-subtract (div) step
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : 33'd0);
        part    = {acc_hi, acc_lo[31]};
        step_hi = sum[32:1];
        step_lo = {sum[0], acc_lo[31:1]};
        if (is_div) begin
            if (part >= {1'b0, mag}) begin
                step_hi = 32'(part - {1'b0, mag});
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = part[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end
        prod = {acc_hi, acc_lo};
        if (neg_q) prod = -prod;
    end

    // Operand latch, iteration datapath and HI/LO write-back
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            mag    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    cnt    <= '0;
                    is_div <= op[1];
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    dbz    <= (b == 32'd0);
                    mag    <= op[1] ? mb : ma;
                    acc_hi <= '0;
                    acc_lo <= op[1] ? ma : mb;
                end
                MD_RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                MD_FIX: begin
                    if (is_div) begin
                        // divide by zero leaves |dividend| as remainder, so
                        // the remainder sign fix restores the dividend itself
                        hi <= neg_r ? -acc_hi : acc_hi;
                        lo <= dbz ? '1 : (neg_q ? -acc_lo : acc_lo);
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch-target add, zero detect and the EX/MEM register.
// Optional build macro MULDIV_EN adds the mult/div unit, HI/LO and stall.
module execute_stage
    import cpu_defs::*;
#(
    parameter int unsigned MD_CYCLES = cpu_defs::MD_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic [31:0] sign_ext_imm,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    output logic        stall,
    output logic [31:0] alu_result,
    output logic [31:0] in_data,
    output logic [4:0]  reg_dest,
    output logic        zero_signal,
    output logic [31:0] branch_target,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        MemToReg,
    output logic        RegWrite
);

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_b, result;
    logic        is_rtype, is_md, is_mf, no_write;

    assign funct    = sign_ext_imm[5:0];
    assign shamt    = sign_ext_imm[10:6];
    assign is_rtype = (ALUOp == ALU_RTYPE);
    assign is_md    = is_rtype & is_muldiv(funct);
    assign is_mf    = is_rtype & ((funct == F_MFHI) | (funct == F_MFLO));

`ifdef MULDIV_EN
    logic        md_busy, md_finishing;
    logic [31:0] md_hi, md_lo;

    muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (is_md & ~md_busy),
        .op        (funct[1:0]),
        .a         (read_data_1),
        .b         (read_data_2),
        .busy      (md_busy),
        .finishing (md_finishing),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    assign stall    = md_busy & (is_md | is_mf);
    assign no_write = is_md;
`else
    assign stall    = 1'b0;
    assign no_write = is_md | is_mf;
`endif

    // ALU operation select
    always_comb begin
        op_b   = ALUSrc ? sign_ext_imm : read_data_2;
        result = '0;
        case (alu_op_e'(ALUOp))
            ALU_SUB:   result = read_data_1 - op_b;
            ALU_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: result = read_data_1 + op_b;
                    F_SUB, F_SUBU: result = read_data_1 - op_b;
                    F_AND:  result = read_data_1 & op_b;
                    F_OR:   result = read_data_1 | op_b;
                    F_XOR:  result = read_data_1 ^ op_b;
                    F_NOR:  result = ~(read_data_1 | op_b);
                    F_SLT:  result = {31'd0, $signed(read_data_1) < $signed(op_b)};
                    F_SLTU: result = {31'd0, read_data_1 < op_b};
                    F_SLL:  result = op_b << shamt;
                    F_SRL:  result = op_b >> shamt;
                    F_SRA:  result = $unsigned($signed(op_b) >>> shamt);
`ifdef MULDIV_EN
                    F_MFHI: result = md_hi;
                    F_MFLO: result = md_lo;
`endif
                    default: result = '0;
                endcase
            end
            default:   result = read_data_1 + op_b;
        endcase
    end

    // EX/MEM pipeline register; a stalled cycle loads a bubble
    always_ff @(posedge clock) begin
        if (!reset_n || stall) begin
            alu_result    <= '0;
            in_data       <= '0;
            reg_dest      <= '0;
            zero_signal   <= 1'b0;
            branch_target <= '0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            Branch        <= 1'b0;
            MemToReg      <= 1'b0;
            RegWrite      <= 1'b0;
        end else begin
            alu_result    <= result;
            in_data       <= read_data_2;
            reg_dest      <= RegDst ? rd : rt;
            zero_signal   <= (result == 32'd0);
            branch_target <= pc_plus4 + {sign_ext_imm[29:0], 2'b00};
            MemRead       <= MemRead_in;
            MemWrite      <= MemWrite_in;
            Branch        <= Branch_in;
            MemToReg      <= MemToReg_in;
            RegWrite      <= RegWrite_in & ~no_write;
        end
    end

endmodule
